eth_rx_frame_parser: RTL and testbench
======================================

ETH_RX_FRAME_PARSER -- requirements
Module: eth_rx_frame_parser

Interface
REQ-001 SHALL have parameter ETHTYPE, default 16'h8888, RAMP Gold ethertype accepted.
REQ-002 SHALL have parameter MAXWORDS, default 512, maximum payload words per frame (used only with REQ-024).
REQ-003 SHALL have ports: clk  input  1  sole clock; all logic on rising edge.
REQ-004 rstn  input  1  reset, synchronous, active-low.
REQ-005 rx_byte  input  8  received byte from MAC, preamble/SFD/FCS already stripped.
REQ-006 rx_valid  input  1  rx_byte valid this cycle; gaps mid-frame allowed.
REQ-007 rx_last  input  1  qualifies rx_byte as final byte of frame (valid with rx_valid only).
REQ-008 rx_err  input  1  MAC FCS/PHY error, sampled with rx_last.
REQ-009 rx_pipe_out  output  eth_rx_pipe_data_type  registered rx pipe stream (stype, msg.header.pid/ptype/seqnum, msg.data).
REQ-010 drop_cnt  output  16  saturating count of frames dropped without rx_start.

Function
REQ-011 Frame layout, in byte order: dst MAC (0-5), src MAC (6-11), ethertype (12-13, big-endian), pid (14), ptype (15), seqnum (16-17), then payload in 4-byte words.
REQ-012 States: IDLE, HDR, PAYLOAD, DISCARD, FLUSH; byte counter 5 bits in HDR, 2-bit lane counter in PAYLOAD.
REQ-013 IDLE: first valid byte -> HDR with byte counter = 1; dst MAC bytes are not checked.
REQ-014 HDR: on byte 13, ethertype != ETHTYPE -> DISCARD, drop_cnt +1.
REQ-015 HDR: on byte 17 -> PAYLOAD; next cycle rx_pipe_out.stype = rx_start with pid, ptype, seqnum[7:0] = byte 16, seqnum[15:8] = byte 17.
REQ-016 HDR: rx_last before byte 17 (runt) -> IDLE, no output, drop_cnt +1.
REQ-017 PAYLOAD: bytes packed little-lane, first byte in msg.data[7:0]; on 4th byte, next cycle stype = rx_data.
REQ-018 PAYLOAD end: on rx_last, frame error flag = rx_err OR partial word pending (lane != 0 after that byte). A partial word is never emitted.
REQ-019 End sequencing: rx_end is emitted the cycle after the last output of the frame. If the last byte completes a word or the header, emit rx_data/rx_start first, then rx_end via FLUSH. rx_end carries msg.data[0] = error flag, msg.data[31:1] = 0.
REQ-020 DISCARD: ignore bytes until rx_last -> IDLE; no output.
REQ-021 rx_pipe_out.stype = rx_none in every cycle not listed above; at most one non-none stype per cycle.
REQ-022 rx_valid low holds all state; the MAC guarantees at least 2 idle cycles between frames. rx_last with rx_valid low is ignored.
REQ-023 drop_cnt saturates at 16'hFFFF.

Configuration
REQ-024 Macro ETH_RX_MAXLEN_CHECK_EN. When defined, the word after MAXWORDS payload words is not emitted; remaining bytes are discarded up to rx_last, then rx_end with data[0] = 1. When undefined, there is no length limit and the word counter is absent.

Reset
REQ-025 rstn low at clk edge -> state IDLE, counters 0, error flag 0, rx_pipe_out.stype = rx_none, msg fields 0, drop_cnt = 0.
REQ-026 Reset mid-frame aborts the frame: no rx_end is emitted, and the remaining bytes after release are parsed as a new frame starting in IDLE.

Verification
REQ-027 Good frame, ethertype 8888, pid 8'h03, ptype cmd, seqnum bytes 34,12, 8 payload bytes 01..08 -> rx_start seqnum 16'h1234; rx_data 32'h04030201; rx_data 32'h08070605; rx_end data[0] = 0, on consecutive cycles when bytes arrive back-to-back.
REQ-028 Same frame with rx_err = 1 on last byte -> identical rx_data, rx_end data[0] = 1.
REQ-029 Ethertype 0800, 60-byte frame -> no rx_pipe_out activity, drop_cnt = 1; 10-byte runt -> drop_cnt = 2.
REQ-030 Payload of 6 bytes -> one rx_data, rx_end data[0] = 1; header-only frame (18 bytes) -> rx_start, then rx_end data[0] = 0 the next cycle.
REQ-031 rx_valid toggled 1-of-3 cycles mid-payload -> same word values as REQ-027; rstn pulsed after 2nd rx_data -> no rx_end, next frame parsed correctly.
REQ-032 With ETH_RX_MAXLEN_CHECK_EN and MAXWORDS = 2, 12 payload bytes -> 2 rx_data then rx_end data[0] = 1; without the macro -> 3 rx_data then rx_end data[0] = 0.

Source files
------------

// File: rtl/eth_rx_frame_parser.sv
// eth_rx_frame_parser: parses MAC-stripped Ethernet bytes into a registered
// rx pipe stream (rx_start / rx_data / rx_end) for one accepted ethertype.
// Optional build macro: ETH_RX_MAXLEN_CHECK_EN enables a payload word limit
// of MAXWORDS words per frame; without it the frame length is unbounded.
//
// Handshake: the input is a valid-only stream. rx_byte, rx_last and rx_err
// are meaningful only when rx_valid is high; there is no ready, the parser
// accepts a byte on every cycle rx_valid is high. The output is also
// valid-only: rx_pipe_out.stype != rx_none marks a one-cycle event.

package eth_rx_pkg;
  typedef enum logic [1:0] {
    rx_none  = 2'd0,
    rx_start = 2'd1,
    rx_data  = 2'd2,
    rx_end   = 2'd3
  } eth_rx_pipe_stype_type;

  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  ptype;
    logic [15:0] seqnum;
  } eth_rx_header_type;

  typedef struct packed {
    eth_rx_header_type header;
    logic [31:0]       data;
  } eth_rx_msg_type;

  typedef struct packed {
    eth_rx_pipe_stype_type stype;
    eth_rx_msg_type        msg;
  } eth_rx_pipe_data_type;
endpackage

module eth_rx_frame_parser
  import eth_rx_pkg::*;
#(
  parameter logic [15:0] ETHTYPE  = 16'h8888,
  parameter int          MAXWORDS = 512
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_valid,
  input  logic                 rx_last,
  input  logic                 rx_err,
  output eth_rx_pipe_data_type rx_pipe_out,
  output logic [15:0]          drop_cnt,
  output logic [2:0]           state_dbg
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_HDR     = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_DISCARD = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;

  logic [2:0]        state;
  logic [4:0]        byte_cnt;
  logic [1:0]        lane;
  logic              err_flag;
  logic              trunc_q;
  logic [7:0]        etype_hi;
  logic [7:0]        pid_q;
  logic [7:0]        ptype_q;
  logic [15:0]       seq_q;
  logic [31:0]       word_q;
  logic [31:0]       word_nxt;
  logic              drop_inc;
  logic              over_limit;
  eth_rx_header_type hdr_q;

`ifdef ETH_RX_MAXLEN_CHECK_EN
  localparam int WCW = $clog2(MAXWORDS + 1);
  logic [WCW-1:0] word_cnt;
  assign over_limit = (word_cnt == WCW'(MAXWORDS));
`else
  localparam int unused_maxwords = MAXWORDS;
  assign over_limit = 1'b0;
`endif

  assign state_dbg = state;
  assign hdr_q     = '{pid: pid_q, ptype: ptype_q, seqnum: seq_q};

  // Merge the incoming byte into its little-endian lane of the word in flight.
  always_comb begin
    word_nxt = word_q;
    case (lane)
      2'd0:    word_nxt[7:0]   = rx_byte;
      2'd1:    word_nxt[15:8]  = rx_byte;
      2'd2:    word_nxt[23:16] = rx_byte;
      default: word_nxt[31:24] = rx_byte;
    endcase
  end

  // A frame is dropped when it ends before the header completes or carries a foreign ethertype.
  always_comb begin
    drop_inc = 1'b0;
    if (rx_valid) begin
      if (state == S_IDLE && rx_last) begin
        drop_inc = 1'b1;
      end else if (state == S_HDR && byte_cnt != 5'd17 &&
                   (rx_last || (byte_cnt == 5'd13 && {etype_hi, rx_byte} != ETHTYPE))) begin
        drop_inc = 1'b1;
      end
    end
  end

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_cnt <= 16'd0;
    end else if (drop_inc && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Frame FSM with registered pipe output; rx_valid low freezes parsing state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= S_IDLE;
      byte_cnt    <= 5'd0;
      lane        <= 2'd0;
      err_flag    <= 1'b0;
      trunc_q     <= 1'b0;
      etype_hi    <= 8'd0;
      pid_q       <= 8'd0;
      ptype_q     <= 8'd0;
      seq_q       <= 16'd0;
      word_q      <= 32'd0;
      rx_pipe_out <= '0;
`ifdef ETH_RX_MAXLEN_CHECK_EN
      word_cnt    <= '0;
`endif
    end else begin
      rx_pipe_out <= '0;
      case (state)
        S_IDLE: begin
          if (rx_valid && !rx_last) begin
            state    <= S_HDR;
            byte_cnt <= 5'd1;
            lane     <= 2'd0;
            err_flag <= 1'b0;
            trunc_q  <= 1'b0;
            word_q   <= 32'd0;
`ifdef ETH_RX_MAXLEN_CHECK_EN
            word_cnt <= '0;
`endif
          end
        end

        S_HDR: begin
          if (rx_valid) begin
            byte_cnt <= byte_cnt + 5'd1;
            case (byte_cnt)
              5'd12:   etype_hi     <= rx_byte;
              5'd14:   pid_q        <= rx_byte;
              5'd15:   ptype_q      <= rx_byte;
              5'd16:   seq_q[7:0]   <= rx_byte;
              5'd17:   seq_q[15:8]  <= rx_byte;
              default: ;
            endcase
            if (byte_cnt == 5'd17) begin
              rx_pipe_out.stype             <= rx_start;
              rx_pipe_out.msg.header.pid    <= pid_q;
              rx_pipe_out.msg.header.ptype  <= ptype_q;
              rx_pipe_out.msg.header.seqnum <= {rx_byte, seq_q[7:0]};
              lane <= 2'd0;
              if (rx_last) begin
                // Header-only frame: rx_end follows rx_start on the next cycle.
                err_flag <= rx_err;
                state    <= S_FLUSH;
              end else begin
                state <= S_PAYLOAD;
              end
            end else if (rx_last) begin
              state <= S_IDLE;
            end else if (byte_cnt == 5'd13 && {etype_hi, rx_byte} != ETHTYPE) begin
              state <= S_DISCARD;
            end
          end
        end

        S_PAYLOAD: begin
          if (rx_valid) begin
            word_q <= word_nxt;
            lane   <= lane + 2'd1;
            if (lane == 2'd3) begin
              if (over_limit) begin
                // Word beyond the limit is swallowed; frame ends flagged as errored.
                trunc_q <= 1'b1;
                if (rx_last) begin
                  rx_pipe_out.stype      <= rx_end;
                  rx_pipe_out.msg.header <= hdr_q;
                  rx_pipe_out.msg.data   <= 32'd1;
                  state                  <= S_IDLE;
                end else begin
                  state <= S_DISCARD;
                end
              end else begin
                rx_pipe_out.stype      <= rx_data;
                rx_pipe_out.msg.header <= hdr_q;
                rx_pipe_out.msg.data   <= word_nxt;
`ifdef ETH_RX_MAXLEN_CHECK_EN
                word_cnt <= word_cnt + WCW'(1);
`endif
                if (rx_last) begin
                  err_flag <= rx_err;
                  state    <= S_FLUSH;
                end
              end
            end else if (rx_last) begin
              // Partial word pending: it is dropped and the frame is flagged.
              rx_pipe_out.stype      <= rx_end;
              rx_pipe_out.msg.header <= hdr_q;
              rx_pipe_out.msg.data   <= 32'd1;
              state                  <= S_IDLE;
            end
          end
        end

        S_DISCARD: begin
          if (rx_valid && rx_last) begin
            if (trunc_q) begin
              rx_pipe_out.stype      <= rx_end;
              rx_pipe_out.msg.header <= hdr_q;
              rx_pipe_out.msg.data   <= 32'd1;
            end
            trunc_q <= 1'b0;
            state   <= S_IDLE;
          end
        end

        S_FLUSH: begin
          rx_pipe_out.stype      <= rx_end;
          rx_pipe_out.msg.header <= hdr_q;
          rx_pipe_out.msg.data   <= {31'd0, err_flag};
          state                  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Directed bench for eth_rx_frame_parser: builds byte frames, drives them,
// captures every non-none pipe event and checks values and spacing inline.
module tb_eth_rx_frame_parser;
  import eth_rx_pkg::*;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [7:0]           rx_byte = 8'd0;
  logic                 rx_valid = 1'b0;
  logic                 rx_last = 1'b0;
  logic                 rx_err = 1'b0;
  eth_rx_pipe_data_type rx_pipe_out;
  logic [15:0]          drop_cnt;
  logic [2:0]           state_dbg;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    eth_rx_pipe_stype_type st;
    logic [31:0]           data;
    logic [15:0]           seq;
    logic [7:0]            pid;
    logic [7:0]            ptype;
    int                    cyc;
  } cap_t;

  cap_t       cap_q[$];
  logic [7:0] frm[$];

  eth_rx_frame_parser #(.ETHTYPE(16'h8888), .MAXWORDS(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .rx_byte    (rx_byte),
    .rx_valid   (rx_valid),
    .rx_last    (rx_last),
    .rx_err     (rx_err),
    .rx_pipe_out(rx_pipe_out),
    .drop_cnt   (drop_cnt),
    .state_dbg  (state_dbg)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Capture pipe events away from the active edge.
  always @(negedge clk) begin
    if (rx_pipe_out.stype != rx_none) begin
      cap_t c;
      c.st    = rx_pipe_out.stype;
      c.data  = rx_pipe_out.msg.data;
      c.seq   = rx_pipe_out.msg.header.seqnum;
      c.pid   = rx_pipe_out.msg.header.pid;
      c.ptype = rx_pipe_out.msg.header.ptype;
      c.cyc   = cyc;
      cap_q.push_back(c);
    end
  end

  task automatic pop_cap(output cap_t e);
    if (cap_q.size() > 0) begin
      e = cap_q.pop_front();
    end else begin
      e.st = rx_none; e.data = 32'hDEAD_BEEF; e.seq = 16'd0;
      e.pid = 8'd0; e.ptype = 8'd0; e.cyc = -1000;
    end
  endtask

  task automatic build_frame(input logic [15:0] etype, input int npay);
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(8'hFF);
    for (int i = 0; i < 6; i++) frm.push_back(8'h10 + 8'(i));
    frm.push_back(etype[15:8]);
    frm.push_back(etype[7:0]);
    frm.push_back(8'h03);
    frm.push_back(8'h01);
    frm.push_back(8'h34);
    frm.push_back(8'h12);
    for (int i = 0; i < npay; i++) frm.push_back(8'(i + 1));
  endtask

  // Drive bytes [from,to); gap idle cycles after each payload byte, with junk on the bus.
  task automatic send_bytes(input int from, input int to, input int gap,
                            input logic mark_last, input logic err);
    for (int i = from; i < to; i++) begin
      rx_valid = 1'b1;
      rx_byte  = frm[i];
      rx_last  = mark_last && (i == to - 1);
      rx_err   = err && mark_last && (i == to - 1);
      @(posedge clk); #1;
      rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
      if (gap > 0 && i >= 18 && i != to - 1) begin
        rx_byte = 8'hEE; rx_last = 1'b1;
        repeat (gap) begin @(posedge clk); #1; end
        rx_last = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0; rx_last = 1'b0; rx_err = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    tests_run++;
    if (rx_pipe_out !== '0) begin
      tests_failed++; $display("FAIL reset_out got %h exp 0", rx_pipe_out);
    end
    tests_run++;
    if (drop_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_drop got %h exp 0", drop_cnt);
    end
    tests_run++;
    if (state_dbg !== 3'd0) begin
      tests_failed++; $display("FAIL reset_state got %0d exp 0", state_dbg);
    end
    rstn = 1'b1;
    idle(2);
  endtask

  task automatic test_good_frame(input logic err, input int gap);
    cap_t s, d1, d2, e;
    cap_q.delete();
    build_frame(16'h8888, 8);
    send_bytes(0, 26, gap, 1'b1, err);
    idle(4);
    tests_run++;
    if (cap_q.size() !== 4) begin
      tests_failed++; $display("FAIL good_count err=%0d gap=%0d got %0d exp 4", err, gap, cap_q.size());
    end
    pop_cap(s); pop_cap(d1); pop_cap(d2); pop_cap(e);
    tests_run++;
    if (s.st !== rx_start || s.seq !== 16'h1234 || s.pid !== 8'h03 || s.ptype !== 8'h01) begin
      tests_failed++;
      $display("FAIL good_start got st=%0d seq=%h pid=%h ptype=%h exp st=1 seq=1234 pid=03 ptype=01",
               s.st, s.seq, s.pid, s.ptype);
    end
    tests_run++;
    if (d1.st !== rx_data || d1.data !== 32'h04030201) begin
      tests_failed++; $display("FAIL good_data1 got st=%0d data=%h exp st=2 data=04030201", d1.st, d1.data);
    end
    tests_run++;
    if (d2.st !== rx_data || d2.data !== 32'h08070605) begin
      tests_failed++; $display("FAIL good_data2 got st=%0d data=%h exp st=2 data=08070605", d2.st, d2.data);
    end
    tests_run++;
    if (e.st !== rx_end || e.data !== {31'd0, err}) begin
      tests_failed++; $display("FAIL good_end got st=%0d data=%h exp st=3 data=%h", e.st, e.data, {31'd0, err});
    end
    tests_run++;
    if (e.cyc - d2.cyc !== 1) begin
      tests_failed++; $display("FAIL good_end_spacing got %0d exp 1", e.cyc - d2.cyc);
    end
    if (gap == 0) begin
      tests_run++;
      if (d1.cyc - s.cyc !== 4 || d2.cyc - d1.cyc !== 4) begin
        tests_failed++;
        $display("FAIL good_data_spacing got %0d,%0d exp 4,4", d1.cyc - s.cyc, d2.cyc - d1.cyc);
      end
    end
  endtask

  task automatic test_drop();
    cap_q.delete();
    build_frame(16'h0800, 42);
    send_bytes(0, 60, 0, 1'b1, 1'b0);
    idle(3);
    tests_run++;
    if (cap_q.size() !== 0 || drop_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL drop_ethertype got events=%0d drop=%0d exp 0,1", cap_q.size(), drop_cnt);
    end
    build_frame(16'h8888, 0);
    send_bytes(0, 10, 0, 1'b1, 1'b0);
    idle(3);
    tests_run++;
    if (cap_q.size() !== 0 || drop_cnt !== 16'd2) begin
      tests_failed++; $display("FAIL drop_runt got events=%0d drop=%0d exp 0,2", cap_q.size(), drop_cnt);
    end
  endtask

  task automatic test_short_payload();
    cap_t s, d1, e;
    cap_q.delete();
    build_frame(16'h8888, 6);
    send_bytes(0, 24, 0, 1'b1, 1'b0);
    idle(3);
    tests_run++;
    if (cap_q.size() !== 3) begin
      tests_failed++; $display("FAIL partial_count got %0d exp 3", cap_q.size());
    end
    pop_cap(s); pop_cap(d1); pop_cap(e);
    tests_run++;
    if (s.st !== rx_start || d1.st !== rx_data || d1.data !== 32'h04030201) begin
      tests_failed++; $display("FAIL partial_data got st=%0d/%0d data=%h exp 1/2 04030201", s.st, d1.st, d1.data);
    end
    tests_run++;
    if (e.st !== rx_end || e.data !== 32'd1 || e.cyc - d1.cyc !== 2) begin
      tests_failed++; $display("FAIL partial_end got st=%0d data=%h gap=%0d exp 3 1 2", e.st, e.data, e.cyc - d1.cyc);
    end
  endtask

  task automatic test_hdr_only();
    cap_t s, e;
    cap_q.delete();
    build_frame(16'h8888, 0);
    send_bytes(0, 18, 0, 1'b1, 1'b0);
    idle(3);
    pop_cap(s); pop_cap(e);
    tests_run++;
    if (s.st !== rx_start || s.seq !== 16'h1234 || cap_q.size() !== 0) begin
      tests_failed++; $display("FAIL hdr_only_start got st=%0d seq=%h extra=%0d exp 1 1234 0", s.st, s.seq, cap_q.size());
    end
    tests_run++;
    if (e.st !== rx_end || e.data !== 32'd0 || e.cyc - s.cyc !== 1) begin
      tests_failed++; $display("FAIL hdr_only_end got st=%0d data=%h gap=%0d exp 3 0 1", e.st, e.data, e.cyc - s.cyc);
    end
    tests_run++;
    if (drop_cnt !== 16'd2) begin
      tests_failed++; $display("FAIL hdr_only_drop got %0d exp 2", drop_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    cap_t s, d1, d2;
    cap_q.delete();
    build_frame(16'h8888, 12);
    send_bytes(0, 26, 0, 1'b0, 1'b0);
    tests_run++;
    if (state_dbg !== 3'd2) begin
      tests_failed++; $display("FAIL midframe_state got %0d exp 2", state_dbg);
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(3);
    pop_cap(s); pop_cap(d1); pop_cap(d2);
    tests_run++;
    if (s.st !== rx_start || d1.data !== 32'h04030201 || d2.data !== 32'h08070605 || cap_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_events got st=%0d d1=%h d2=%h extra=%0d exp 1 04030201 08070605 0",
               s.st, d1.data, d2.data, cap_q.size());
    end
    tests_run++;
    if (state_dbg !== 3'd0 || drop_cnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_mid_state got state=%0d drop=%0d exp 0 0", state_dbg, drop_cnt);
    end
    // The four leftover bytes form a runt frame of their own.
    send_bytes(26, 30, 0, 1'b1, 1'b0);
    idle(3);
    tests_run++;
    if (cap_q.size() !== 0 || drop_cnt !== 16'd1) begin
      tests_failed++; $display("FAIL reset_tail got events=%0d drop=%0d exp 0 1", cap_q.size(), drop_cnt);
    end
  endtask

  task automatic test_long_payload();
    cap_t ev[$];
    cap_t t;
    int   exp_n;
    logic [31:0] exp_end;
    cap_q.delete();
    build_frame(16'h8888, 12);
    send_bytes(0, 30, 0, 1'b1, 1'b0);
    idle(3);
`ifdef ETH_RX_MAXLEN_CHECK_EN
    exp_n = 4; exp_end = 32'd1;
`else
    exp_n = 5; exp_end = 32'd0;
`endif
    tests_run++;
    if (cap_q.size() !== exp_n) begin
      tests_failed++; $display("FAIL long_count got %0d exp %0d", cap_q.size(), exp_n);
    end
    for (int i = 0; i < exp_n; i++) begin pop_cap(t); ev.push_back(t); end
    tests_run++;
    if (ev[1].data !== 32'h04030201 || ev[2].data !== 32'h08070605) begin
      tests_failed++; $display("FAIL long_words got %h %h exp 04030201 08070605", ev[1].data, ev[2].data);
    end
    tests_run++;
    if (ev[exp_n-1].st !== rx_end || ev[exp_n-1].data !== exp_end) begin
      tests_failed++; $display("FAIL long_end got st=%0d data=%h exp 3 %h", ev[exp_n-1].st, ev[exp_n-1].data, exp_end);
    end
`ifndef ETH_RX_MAXLEN_CHECK_EN
    tests_run++;
    if (ev[3].st !== rx_data || ev[3].data !== 32'h0C0B0A09) begin
      tests_failed++; $display("FAIL long_word3 got st=%0d data=%h exp 2 0c0b0a09", ev[3].st, ev[3].data);
    end
`endif
  endtask

  task automatic test_back_to_back();
    cap_t t;
    cap_t ev[$];
    cap_q.delete();
    build_frame(16'h8888, 8);
    send_bytes(0, 26, 0, 1'b1, 1'b1);
    idle(2);
    frm[16] = 8'h78; frm[17] = 8'h56;
    send_bytes(0, 26, 0, 1'b1, 1'b0);
    idle(4);
    tests_run++;
    if (cap_q.size() !== 8) begin
      tests_failed++; $display("FAIL b2b_count got %0d exp 8", cap_q.size());
    end
    for (int i = 0; i < 8; i++) begin pop_cap(t); ev.push_back(t); end
    tests_run++;
    if (ev[3].st !== rx_end || ev[3].data !== 32'd1) begin
      tests_failed++; $display("FAIL b2b_end1 got st=%0d data=%h exp 3 1", ev[3].st, ev[3].data);
    end
    tests_run++;
    if (ev[4].st !== rx_start || ev[4].seq !== 16'h5678) begin
      tests_failed++; $display("FAIL b2b_start2 got st=%0d seq=%h exp 1 5678", ev[4].st, ev[4].seq);
    end
    tests_run++;
    if (ev[6].data !== 32'h08070605 || ev[7].st !== rx_end || ev[7].data !== 32'd0) begin
      tests_failed++;
      $display("FAIL b2b_tail got d=%h st=%0d end=%h exp 08070605 3 0", ev[6].data, ev[7].st, ev[7].data);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame(1'b0, 0);
    test_good_frame(1'b1, 0);
    test_drop();
    test_short_payload();
    test_hdr_only();
    test_good_frame(1'b0, 2);
    test_reset_mid_frame();
    test_long_payload();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
